// File: rtl/uart_tx_pkg.sv
// Shared types and line constants for the UART transmit path.
// Pure definitions: no timing, no flow control.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic START_BIT  = 1'b0;
   localparam logic STOP_BIT   = 1'b1;
   localparam logic IDLE_LEVEL = 1'b1;

   // Bit-index counter width; never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_tx_frame_ctrl_if.sv
// Parallel request side and serial line of the UART frame controller.
// Request is a strobe accepted only while idle; Busy is the only backpressure.
interface uart_tx_frame_ctrl_if #(
   parameter int DATA_WIDTH = 8
);

   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  Data_Valid;
   logic                  PAR_EN;
   logic                  par_bit;
   logic                  TX_OUT;
   logic                  Busy;

   modport master (
      output P_DATA,
      output Data_Valid,
      output PAR_EN,
      output par_bit,
      input  TX_OUT,
      input  Busy
   );

   modport slave (
      input  P_DATA,
      input  Data_Valid,
      input  PAR_EN,
      input  par_bit,
      output TX_OUT,
      output Busy
   );

endinterface

// File: rtl/uart_tx_serializer.sv
// Data shift register plus bit-index counter; ser_out is the next data bit to drive.
// Loads in one cycle, shifts one bit per shift_en; no backpressure.
module uart_tx_serializer
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  load,
   input  logic                  shift_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  ser_out,
   output logic                  last_bit
);

   localparam int              CW       = cnt_width(DATA_WIDTH);
   localparam logic [CW-1:0]   CNT_LAST = CW'(DATA_WIDTH - 1);

   logic [DATA_WIDTH-1:0] shreg;
   logic [CW-1:0]         cnt;

   // The counter is preset on load so the shift taken during the start bit
   // wraps it to 0, leaving cnt equal to the index of the bit on the line.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         shreg <= '0;
         cnt   <= '0;
      end else if (load) begin
         shreg <= data_in;
         cnt   <= CNT_LAST;
      end else if (shift_en) begin
         shreg <= {STOP_BIT, shreg[DATA_WIDTH-1:1]};
         cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      end
   end

   assign ser_out  = shreg[0];
   assign last_bit = (cnt == CNT_LAST);

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART framer: start, LSB-first data, optional parity, stop; one bit per baud CLK.
// Start bit one cycle after acceptance; requests while Busy are dropped, not queued.
module uart_tx_frame_ctrl
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int STOP_BITS  = 1
) (
   input logic                  CLK,
   input logic                  RST,
   uart_tx_frame_ctrl_if.slave  bus
);

   state_t state;
   state_t next_state;

   logic par_en_q;
   logic par_q;
   logic stop_cnt;
   logic stop_done;
   logic tx_q;
   logic busy_q;
   logic tx_nxt;
   logic busy_nxt;
   logic load;
   logic shift_en;
   logic ser_out;
   logic last_bit;

   assign load      = (state == IDLE) && bus.Data_Valid;
   assign shift_en  = (state == START) || (state == DATA);
   assign stop_done = (STOP_BITS == 1) || stop_cnt;

   uart_tx_serializer #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ser (
      .CLK      (CLK),
      .RST      (RST),
      .load     (load),
      .shift_en (shift_en),
      .data_in  (bus.P_DATA),
      .ser_out  (ser_out),
      .last_bit (last_bit)
   );

   // par_bit from upstream is only meaningful during the start-bit cycle.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state    <= IDLE;
         tx_q     <= IDLE_LEVEL;
         busy_q   <= 1'b0;
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
         stop_cnt <= 1'b0;
      end else begin
         state    <= next_state;
         tx_q     <= tx_nxt;
         busy_q   <= busy_nxt;
         stop_cnt <= (state == STOP) && !stop_done;
         if (load) begin
            par_en_q <= bus.PAR_EN;
         end
         if (state == START) begin
            par_q <= bus.par_bit;
         end
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (bus.Data_Valid) next_state = START;
         START:   next_state = DATA;
         DATA:    if (last_bit) next_state = par_en_q ? PARITY : STOP;
         PARITY:  next_state = STOP;
         STOP:    if (stop_done) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Line level is registered, so it is chosen from the state being entered.
   always_comb begin
      tx_nxt   = IDLE_LEVEL;
      busy_nxt = (next_state != IDLE);
      case (next_state)
         START:   tx_nxt = START_BIT;
         DATA:    tx_nxt = ser_out;
         PARITY:  tx_nxt = par_q;
         STOP:    tx_nxt = STOP_BIT;
         default: tx_nxt = IDLE_LEVEL;
      endcase
   end

   assign bus.TX_OUT = tx_q;
   assign bus.Busy   = busy_q;

endmodule
